requant_unit: RTL

- Post-processing stage directly downstream of the TPU's C global buffer.
- Reads 128-bit C entries, each holding four int32 accumulators, and requantizes each lane TFLite-style: bias add, fixed-point multiply, rounding right shift, output offset, clamp.
- Packs the four int8 results into one 32-bit word and streams it to the CFU response path with a valid/ready handshake.
- While busy, the CFU uses `busy` to mux this block's C_index onto the C buffer.

---
 rtl/requant_unit_pkg.sv | 49 ++++
 rtl/requant_unit_if.sv | 29 ++
 rtl/requant_unit_lane.sv | 64 ++++++
 rtl/requant_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/requant_unit_pkg.sv
// Shared definitions for the requantization unit: config map, FSM encodings,
// numeric limits and the reset configuration.
package requant_unit_pkg;

  localparam logic [3:0] CFG_BIAS0   = 4'd0;
  localparam logic [3:0] CFG_BIAS1   = 4'd1;
  localparam logic [3:0] CFG_BIAS2   = 4'd2;
  localparam logic [3:0] CFG_BIAS3   = 4'd3;
  localparam logic [3:0] CFG_MULT    = 4'd4;
  localparam logic [3:0] CFG_SHIFT   = 4'd5;
  localparam logic [3:0] CFG_OFFSET  = 4'd6;
  localparam logic [3:0] CFG_ACT_MIN = 4'd7;
  localparam logic [3:0] CFG_ACT_MAX = 4'd8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_MUL  = 3'd3;
  localparam state_t ST_SHF  = 3'd4;
  localparam state_t ST_OUT  = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

  localparam logic [31:0] MULT_RST    = 32'h4000_0000;
  localparam logic [7:0]  ACT_MIN_RST = 8'h80;
  localparam logic [7:0]  ACT_MAX_RST = 8'h7F;

  typedef struct packed {
    logic [3:0][31:0] bias;
    logic [31:0]      mult;
    logic [4:0]       shift;
    logic [31:0]      offset;
    logic [7:0]       act_min;
    logic [7:0]       act_max;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    bias:    '0,
    mult:    MULT_RST,
    shift:   '0,
    offset:  '0,
    act_min: ACT_MIN_RST,
    act_max: ACT_MAX_RST
  };

endpackage

// File: rtl/requant_unit_if.sv
// Job control, config, C-buffer read and result stream signals of requant_unit.
interface requant_unit_if #(
  parameter int ADDR_BITS = 12,
  parameter int C_BITS    = 128
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_index;
  logic [ADDR_BITS:0]   count;
  logic                 cfg_wr;
  logic [3:0]           cfg_addr;
  logic [31:0]          cfg_data;
  logic [ADDR_BITS-1:0] C_index;
  logic [C_BITS-1:0]    C_data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, base_index, count, cfg_wr, cfg_addr, cfg_data, C_data_out, out_ready,
    output C_index, out_valid, out_data, busy, done
  );

  modport master (
    output start, base_index, count, cfg_wr, cfg_addr, cfg_data, C_data_out, out_ready,
    input  C_index, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/requant_unit_lane.sv
// One requantization lane: bias add, SRDHM, rounding shift, offset and clamp,
// each stage registered and advanced by the parent FSM.
module requant_lane
  import requant_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_add_i,
  input  logic        en_mul_i,
  input  logic        en_shf_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] bias_i,
  input  logic [31:0] mult_i,
  input  logic [4:0]  shift_i,
  input  logic [31:0] offset_i,
  input  logic [7:0]  act_min_i,
  input  logic [7:0]  act_max_i,
  output logic [7:0]  q_o
);
  logic [31:0]        a_q, a_d, m_q, m_d;
  logic [7:0]         q_q, q_d;
  logic signed [63:0] prod, sum;
  logic [31:0]        mask, rem, thr, sh_r, r, v;
  logic signed [31:0] lo, hi;

  always_comb begin
    a_d  = acc_i + bias_i;

    prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{mult_i[31]}}, mult_i});
    sum  = prod + (prod[63] ? -64'sd1073741823 : 64'sd1073741824);
    // Biasing negative sums by 2^31-1 turns the arithmetic shift into truncation toward zero.
    if (a_q == INT32_MIN && mult_i == INT32_MIN) m_d = INT32_MAX;
    else m_d = 32'((sum + (sum[63] ? 64'sd2147483647 : 64'sd0)) >>> 31);

    mask = (32'd1 << shift_i) - 32'd1;
    rem  = m_q & mask;
    thr  = (mask >> 1) + {31'd0, m_q[31]};
    sh_r = $signed(m_q) >>> shift_i;
    r    = sh_r + {31'd0, (rem > thr)};
    v    = r + offset_i;

    lo = $signed({{24{act_min_i[7]}}, act_min_i});
    hi = $signed({{24{act_max_i[7]}}, act_max_i});
    if (lo > hi)               q_d = act_max_i;
    else if ($signed(v) < lo)  q_d = act_min_i;
    else if ($signed(v) > hi)  q_d = act_max_i;
    else                       q_d = v[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      m_q <= '0;
      q_q <= '0;
    end else begin
      if (en_add_i) a_q <= a_d;
      if (en_mul_i) m_q <= m_d;
      if (en_shf_i) q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/requant_unit.sv
// Requantizes C-buffer entries (4 x int32) to packed int8 words and streams
// them out with a valid/ready handshake.
module requant_unit
  import requant_unit_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int C_BITS    = 128
) (
  input logic           clk,
  input logic           reset,
  requant_unit_if.slave bus
);
  localparam int LANE_BITS = C_BITS / 4;

  state_t               state_q, state_d;
  cfg_t                 cfg_q, cfg_d;
  logic [ADDR_BITS:0]   count_q, count_d, i_q, i_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 hs, last;
  logic [3:0][7:0]      lane_q;

  assign hs   = (state_q == ST_OUT) && out_valid_q && bus.out_ready;
  assign last = (i_q + (ADDR_BITS+1)'(1)) == count_q;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    count_d     = count_q;
    i_d         = i_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_wr) begin
          case (bus.cfg_addr)
            CFG_BIAS0, CFG_BIAS1,
            CFG_BIAS2, CFG_BIAS3: cfg_d.bias[bus.cfg_addr[1:0]] = bus.cfg_data;
            CFG_MULT:             cfg_d.mult    = bus.cfg_data;
            CFG_SHIFT:            cfg_d.shift   = bus.cfg_data[4:0];
            CFG_OFFSET:           cfg_d.offset  = bus.cfg_data;
            CFG_ACT_MIN:          cfg_d.act_min = bus.cfg_data[7:0];
            CFG_ACT_MAX:          cfg_d.act_max = bus.cfg_data[7:0];
            default: ;
          endcase
        end
        if (bus.start) begin
          count_d = bus.count;
          i_d     = '0;
          idx_d   = bus.base_index;
          state_d = (bus.count == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_MUL;
      ST_MUL:  state_d = ST_SHF;
      ST_SHF: begin
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          i_d         = i_q + (ADDR_BITS+1)'(1);
          if (last) state_d = ST_DONE;
          else begin
            state_d = ST_RD;
            idx_d   = idx_q + ADDR_BITS'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cfg_q       <= CFG_RST;
      count_q     <= '0;
      i_q         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      count_q     <= count_d;
      i_q         <= i_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    requant_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .en_add_i  (state_q == ST_WAIT),
      .en_mul_i  (state_q == ST_MUL),
      .en_shf_i  (state_q == ST_SHF),
      .acc_i     (bus.C_data_out[l*LANE_BITS +: LANE_BITS]),
      .bias_i    (cfg_q.bias[l]),
      .mult_i    (cfg_q.mult),
      .shift_i   (cfg_q.shift),
      .offset_i  (cfg_q.offset),
      .act_min_i (cfg_q.act_min),
      .act_max_i (cfg_q.act_max),
      .q_o       (lane_q[l])
    );
  end

  assign bus.C_index   = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = lane_q;
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);

endmodule
